fix_serializer: RTL

// - Transmit-side counterpart of the FIX parser: converts a sequence of tag/value fields into the framed FIX byte stream.
// - Per message: 0x00 start marker, then "tag=value<SOH>" for each field, then trailer "10=ddd<SOH>".
// - Computes the FIX checksum on the fly. Feeds a loopback path into fix_parser / fix_checksum or a downstream byte link.

---
 rtl/fix_serializer.sv | 223 ++++++++++++++++++++++
 1 files changed

// File: rtl/fix_serializer.sv
// fix_serializer: turns a sequence of tag/value fields into a framed FIX byte
// stream: 0x00 marker, "tag=value<SOH>" per field, then "10=ddd<SOH>".
// The checksum covers every body byte from the first tag byte through the last
// body SOH, and is computed on the fly.
// Optional build macro FIX_SER_CKSUM_INJ_EN adds err_inject, which flips bit 0
// of the transmitted checksum so that a receiver's bad-checksum path can be
// exercised.
module fix_serializer #(
   parameter int DATA_WIDTH  = 8,
   parameter int TAG_WIDTH   = 24,
   parameter int VALUE_WIDTH = 21*8,
   parameter int LEN_WIDTH   = 5
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   fld_valid,
   output logic                   fld_ready,
   input  logic [TAG_WIDTH-1:0]   fld_tag,
   input  logic [VALUE_WIDTH-1:0] fld_value,
   input  logic [LEN_WIDTH-1:0]   fld_len,
   input  logic                   fld_last,
`ifdef FIX_SER_CKSUM_INJ_EN
   input  logic                   err_inject,
`endif
   output logic [DATA_WIDTH-1:0]  tx_data,
   output logic                   tx_valid,
   input  logic                   tx_ready,
   output logic                   busy,
   output logic                   msg_done,
   output logic [7:0]             cksum
);

   localparam logic [3:0] S_IDLE = 4'd0;
   localparam logic [3:0] S_PRE  = 4'd1;
   localparam logic [3:0] S_TAG  = 4'd2;
   localparam logic [3:0] S_EQ   = 4'd3;
   localparam logic [3:0] S_VAL  = 4'd4;
   localparam logic [3:0] S_SOH  = 4'd5;
   localparam logic [3:0] S_WAIT = 4'd6;
   localparam logic [3:0] S_CKT  = 4'd7;
   localparam logic [3:0] S_CKD  = 4'd8;
   localparam logic [3:0] S_CKS  = 4'd9;

   localparam logic [LEN_WIDTH-1:0] MAX_LEN = LEN_WIDTH'(21);
   localparam logic [LEN_WIDTH-1:0] ONE     = LEN_WIDTH'(1);
   localparam logic [LEN_WIDTH-1:0] TWO     = LEN_WIDTH'(2);

   logic [3:0]             state;
   logic [TAG_WIDTH-1:0]   tag_r;
   logic [VALUE_WIDTH-1:0] val_r;
   logic [LEN_WIDTH-1:0]   len_r;
   logic                   last_r;
   logic                   inj_r;
   logic [LEN_WIDTH-1:0]   cnt;      // index of the byte currently presented within its group
   logic [7:0]             acc;
   logic [7:0]             cs_frz;
   logic [3:0]             dig_h, dig_t, dig_o;
   logic [7:0]             cs_fin;
   logic [LEN_WIDTH-1:0]   len_c;
   logic                   hs;

   // Index of the first tag byte to send: leading zero bytes are skipped, byte 0 always goes.
   function automatic logic [LEN_WIDTH-1:0] first_idx(input logic [TAG_WIDTH-1:0] t);
      if (t[23:16] != 8'h00)     return TWO;
      else if (t[15:8] != 8'h00) return ONE;
      else                       return '0;
   endfunction

   function automatic logic [7:0] tag_byte(input logic [TAG_WIDTH-1:0] t, input logic [LEN_WIDTH-1:0] i);
      return 8'(t >> (8 * i));
   endfunction

   function automatic logic [7:0] val_byte(input logic [VALUE_WIDTH-1:0] v, input logic [LEN_WIDTH-1:0] i);
      return 8'(v >> (8 * i));
   endfunction

   assign fld_ready = (state == S_IDLE) || (state == S_WAIT);
   assign busy      = (state != S_IDLE);
   assign hs        = tx_valid && tx_ready;
   assign len_c     = (fld_len > MAX_LEN) ? MAX_LEN : fld_len;

   // Final checksum as it stands on the last body SOH handshake (that SOH included).
   always_comb begin
      cs_fin = acc + tx_data[7:0];
`ifdef FIX_SER_CKSUM_INJ_EN
      cs_fin = cs_fin ^ {7'b0, inj_r};
`endif
   end

   // Byte sequencer: the state names the byte currently presented; each handshake loads the next one.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= S_IDLE;
         tx_data  <= '0;
         tx_valid <= 1'b0;
         msg_done <= 1'b0;
         cksum    <= '0;
         acc      <= '0;
         cs_frz   <= '0;
         dig_h    <= '0;
         dig_t    <= '0;
         dig_o    <= '0;
         tag_r    <= '0;
         val_r    <= '0;
         len_r    <= '0;
         last_r   <= 1'b0;
         inj_r    <= 1'b0;
         cnt      <= '0;
      end else begin
         msg_done <= 1'b0;
         if (fld_ready) begin
            if (fld_valid) begin
               tag_r    <= fld_tag;
               val_r    <= fld_value;
               len_r    <= len_c;
               last_r   <= fld_last;
`ifdef FIX_SER_CKSUM_INJ_EN
               if (fld_last) inj_r <= err_inject;
`endif
               tx_valid <= 1'b1;
               if (state == S_IDLE) begin
                  state   <= S_PRE;
                  tx_data <= '0;
               end else begin
                  state   <= S_TAG;
                  cnt     <= first_idx(fld_tag);
                  tx_data <= DATA_WIDTH'(tag_byte(fld_tag, first_idx(fld_tag)));
               end
            end
         end else if (hs) begin
            if (state == S_TAG || state == S_EQ || state == S_VAL || state == S_SOH)
               acc <= acc + tx_data[7:0];
            case (state)
               S_PRE: begin
                  state   <= S_TAG;
                  cnt     <= first_idx(tag_r);
                  tx_data <= DATA_WIDTH'(tag_byte(tag_r, first_idx(tag_r)));
               end
               S_TAG: begin
                  if (cnt == '0) begin
                     state   <= S_EQ;
                     tx_data <= DATA_WIDTH'(8'h3D);
                  end else begin
                     cnt     <= cnt - ONE;
                     tx_data <= DATA_WIDTH'(tag_byte(tag_r, cnt - ONE));
                  end
               end
               S_EQ: begin
                  if (len_r == '0) begin
                     state   <= S_SOH;
                     tx_data <= DATA_WIDTH'(8'h01);
                  end else begin
                     state   <= S_VAL;
                     cnt     <= len_r - ONE;
                     tx_data <= DATA_WIDTH'(val_byte(val_r, len_r - ONE));
                  end
               end
               S_VAL: begin
                  if (cnt == '0) begin
                     state   <= S_SOH;
                     tx_data <= DATA_WIDTH'(8'h01);
                  end else begin
                     cnt     <= cnt - ONE;
                     tx_data <= DATA_WIDTH'(val_byte(val_r, cnt - ONE));
                  end
               end
               S_SOH: begin
                  if (last_r) begin
                     // Freeze the checksum and split it into decimal digits once, here.
                     state   <= S_CKT;
                     cnt     <= TWO;
                     tx_data <= DATA_WIDTH'(8'h31);
                     cs_frz  <= cs_fin;
                     dig_h   <= 4'(cs_fin / 8'd100);
                     dig_t   <= 4'((cs_fin / 8'd10) % 8'd10);
                     dig_o   <= 4'(cs_fin % 8'd10);
                  end else begin
                     state    <= S_WAIT;
                     tx_valid <= 1'b0;
                  end
               end
               S_CKT: begin
                  if (cnt == TWO) begin
                     cnt     <= ONE;
                     tx_data <= DATA_WIDTH'(8'h30);
                  end else if (cnt == ONE) begin
                     cnt     <= '0;
                     tx_data <= DATA_WIDTH'(8'h3D);
                  end else begin
                     state   <= S_CKD;
                     cnt     <= TWO;
                     tx_data <= DATA_WIDTH'({4'h3, dig_h});
                  end
               end
               S_CKD: begin
                  if (cnt == TWO) begin
                     cnt     <= ONE;
                     tx_data <= DATA_WIDTH'({4'h3, dig_t});
                  end else if (cnt == ONE) begin
                     cnt     <= '0;
                     tx_data <= DATA_WIDTH'({4'h3, dig_o});
                  end else begin
                     state   <= S_CKS;
                     tx_data <= DATA_WIDTH'(8'h01);
                  end
               end
               S_CKS: begin
                  state    <= S_IDLE;
                  tx_valid <= 1'b0;
                  msg_done <= 1'b1;
                  cksum    <= cs_frz;
                  acc      <= '0;
               end
               default: begin
                  state    <= S_IDLE;
                  tx_valid <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule
